// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared encodings for the MIPS pipeline hazard logic
package mips_pkg;

    localparam logic [1:0] MTR_ALU  = 2'b00;
    localparam logic [1:0] MTR_LO   = 2'b01;
    localparam logic [1:0] MTR_HI   = 2'b10;
    localparam logic [1:0] MTR_LOAD = 2'b11;

    // GPR forward selects (E stage)
    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_M  = 2'b10;
    localparam logic [1:0] FWD_W  = 2'b01;

    // HI/LO forward selects use the opposite M/W coding
    localparam logic [1:0] HL_RF = 2'b00;
    localparam logic [1:0] HL_M  = 2'b01;
    localparam logic [1:0] HL_W  = 2'b10;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_BUSY = 2'b01,
        MD_DONE = 2'b10
    } md_state_t;

endpackage

// File: rtl/md_seq.sv
// rtl/md_seq.sv - MUL/DIV occupancy sequencer holding the op in E
module md_seq
    import mips_pkg::*;
#(
    parameter int DIV_LAT = 32,
    parameter int MUL_LAT = 2,
    parameter int CNT_W   = 6
) (
    input  logic clk,
    input  logic rst_n,
    input  logic div_start,
    input  logic mul_start,
    input  logic abort,
    output logic md_stall,
    output logic md_busy
);

    localparam logic [CNT_W-1:0] DIV_INIT   = CNT_W'(DIV_LAT - 1);
    localparam logic [CNT_W-1:0] MUL_INIT   = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(1);
    localparam logic             MUL_STALLS = (MUL_LAT > 1) ? 1'b1 : 1'b0;

    md_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             start;

    assign start = div_start | (mul_start & MUL_STALLS);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (abort) begin
            state_d = MD_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                MD_IDLE: begin
                    if (div_start) begin
                        state_d = MD_BUSY;
                        cnt_d   = DIV_INIT;
                    end else if (mul_start && MUL_STALLS) begin
                        state_d = MD_BUSY;
                        cnt_d   = MUL_INIT;
                    end
                end
                MD_BUSY: begin
                    cnt_d = cnt_q - CNT_LAST;
                    if (cnt_q == CNT_LAST) begin
                        state_d = MD_DONE;
                    end
                end
                MD_DONE: state_d = MD_IDLE;
                default: begin
                    state_d = MD_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // DONE releases E on its closing edge, so it must not stall
    assign md_stall = ((state_q == MD_IDLE) & start) | (state_q == MD_BUSY);
    assign md_busy  = (state_q != MD_IDLE);

endmodule

// File: rtl/hazard_unit_mc.sv
// rtl/hazard_unit_mc.sv - hazard, forwarding, MUL/DIV stall and exception flush control
module hazard_unit_mc
    import mips_pkg::*;
#(
    parameter int REG_AW  = 5,
    parameter int DIV_LAT = 32,
    parameter int MUL_LAT = 2,
    parameter int CNT_W   = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] RsD,
    input  logic [REG_AW-1:0] RtD,
    input  logic              BranchD,
    input  logic [REG_AW-1:0] RsE,
    input  logic [REG_AW-1:0] RtE,
    input  logic [REG_AW-1:0] WriteRegE,
    input  logic              RegWriteE,
    input  logic [1:0]        MemtoRegE,
    input  logic              MulStartE,
    input  logic              DivStartE,
    input  logic [REG_AW-1:0] WriteRegM,
    input  logic [REG_AW-1:0] WriteRegW,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    input  logic [1:0]        MemtoRegM,
    input  logic              HIWriteM,
    input  logic              LOWriteM,
    input  logic              HIWriteW,
    input  logic              LOWriteW,
    input  logic              ExceptM,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              FlushD,
    output logic              FlushE,
    output logic              FlushM,
    output logic              ForwardAD,
    output logic              ForwardBD,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic [1:0]        ForwardHIE,
    output logic [1:0]        ForwardLOE,
    output logic              MdBusy
);

    localparam logic [REG_AW-1:0] R0 = '0;

    logic md_stall;
    logic lw_stall, br_stall, hz_stall;
    logic wr_e_hit, ld_m_hit;

    md_seq #(
        .DIV_LAT(DIV_LAT),
        .MUL_LAT(MUL_LAT),
        .CNT_W  (CNT_W)
    ) u_md_seq (
        .clk      (clk),
        .rst_n    (rst),
        .div_start(DivStartE),
        .mul_start(MulStartE),
        .abort    (ExceptM),
        .md_stall (md_stall),
        .md_busy  (MdBusy)
    );

    function automatic logic [1:0] gpr_sel(input logic [REG_AW-1:0] src,
                                           input logic [REG_AW-1:0] dst_m, input logic we_m,
                                           input logic [REG_AW-1:0] dst_w, input logic we_w);
        if (src != R0 && we_m && dst_m == src) return FWD_M;
        if (src != R0 && we_w && dst_w == src) return FWD_W;
        return FWD_RF;
    endfunction

    assign ForwardAE = gpr_sel(RsE, WriteRegM, RegWriteM, WriteRegW, RegWriteW);
    assign ForwardBE = gpr_sel(RtE, WriteRegM, RegWriteM, WriteRegW, RegWriteW);

    // D-stage compare path only has the M ALU result, never load or HI/LO data
    assign ForwardAD = (RsD != R0) && RegWriteM && (MemtoRegM == MTR_ALU) && (WriteRegM == RsD);
    assign ForwardBD = (RtD != R0) && RegWriteM && (MemtoRegM == MTR_ALU) && (WriteRegM == RtD);

    assign ForwardHIE = (MemtoRegE != MTR_HI) ? HL_RF : HIWriteM ? HL_M : HIWriteW ? HL_W : HL_RF;
    assign ForwardLOE = (MemtoRegE != MTR_LO) ? HL_RF : LOWriteM ? HL_M : LOWriteW ? HL_W : HL_RF;

    assign lw_stall = (MemtoRegE == MTR_LOAD) && (RtE != R0) && (RtE == RsD || RtE == RtD);
    assign wr_e_hit = RegWriteE && (WriteRegE != R0) && (WriteRegE == RsD || WriteRegE == RtD);
    assign ld_m_hit = (MemtoRegM == MTR_LOAD) && (WriteRegM != R0) && (WriteRegM == RsD || WriteRegM == RtD);
    assign br_stall = BranchD && (wr_e_hit || ld_m_hit);
    assign hz_stall = lw_stall | br_stall;

    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushM = 1'b0;
        if (ExceptM) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
            FlushM = 1'b1;
        end else begin
            StallF = hz_stall | md_stall;
            StallD = hz_stall | md_stall;
            StallE = md_stall;
            FlushE = hz_stall & ~md_stall;
            FlushM = md_stall;
        end
    end

endmodule

// File: tb/tb_hazard_unit_mc.sv
// tb/tb_hazard_unit_mc.sv - directed scoreboard bench for hazard_unit_mc
module tb_hazard_unit_mc;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
    logic       BranchD, RegWriteE, MulStartE, DivStartE, RegWriteM, RegWriteW;
    logic [1:0] MemtoRegE, MemtoRegM;
    logic       HIWriteM, LOWriteM, HIWriteW, LOWriteW, ExceptM;

    logic       StallF0, StallD0, StallE0, FlushD0, FlushE0, FlushM0, ForwardAD0, ForwardBD0, MdBusy0;
    logic [1:0] ForwardAE0, ForwardBE0, ForwardHIE0, ForwardLOE0;
    logic       StallF1, StallD1, StallE1, FlushD1, FlushE1, FlushM1, ForwardAD1, ForwardBD1, MdBusy1;
    logic [1:0] ForwardAE1, ForwardBE1, ForwardHIE1, ForwardLOE1;

    logic [16:0] obs0, obs1;
    logic [16:0] exp_q[$];
    string       tag_q[$];
    int          total = 0;
    int          bad   = 0;
    int          n_all, n_any, n_busy;

    always #5 clk = ~clk;

    hazard_unit_mc #(.REG_AW(5), .DIV_LAT(32), .MUL_LAT(2), .CNT_W(6)) u0 (
        .clk(clk), .rst(rst), .RsD(RsD), .RtD(RtD), .BranchD(BranchD),
        .RsE(RsE), .RtE(RtE), .WriteRegE(WriteRegE), .RegWriteE(RegWriteE),
        .MemtoRegE(MemtoRegE), .MulStartE(MulStartE), .DivStartE(DivStartE),
        .WriteRegM(WriteRegM), .WriteRegW(WriteRegW), .RegWriteM(RegWriteM),
        .RegWriteW(RegWriteW), .MemtoRegM(MemtoRegM), .HIWriteM(HIWriteM),
        .LOWriteM(LOWriteM), .HIWriteW(HIWriteW), .LOWriteW(LOWriteW), .ExceptM(ExceptM),
        .StallF(StallF0), .StallD(StallD0), .StallE(StallE0), .FlushD(FlushD0),
        .FlushE(FlushE0), .FlushM(FlushM0), .ForwardAD(ForwardAD0), .ForwardBD(ForwardBD0),
        .ForwardAE(ForwardAE0), .ForwardBE(ForwardBE0), .ForwardHIE(ForwardHIE0),
        .ForwardLOE(ForwardLOE0), .MdBusy(MdBusy0)
    );

    hazard_unit_mc #(.REG_AW(5), .DIV_LAT(32), .MUL_LAT(1), .CNT_W(6)) u1 (
        .clk(clk), .rst(rst), .RsD(RsD), .RtD(RtD), .BranchD(BranchD),
        .RsE(RsE), .RtE(RtE), .WriteRegE(WriteRegE), .RegWriteE(RegWriteE),
        .MemtoRegE(MemtoRegE), .MulStartE(MulStartE), .DivStartE(DivStartE),
        .WriteRegM(WriteRegM), .WriteRegW(WriteRegW), .RegWriteM(RegWriteM),
        .RegWriteW(RegWriteW), .MemtoRegM(MemtoRegM), .HIWriteM(HIWriteM),
        .LOWriteM(LOWriteM), .HIWriteW(HIWriteW), .LOWriteW(LOWriteW), .ExceptM(ExceptM),
        .StallF(StallF1), .StallD(StallD1), .StallE(StallE1), .FlushD(FlushD1),
        .FlushE(FlushE1), .FlushM(FlushM1), .ForwardAD(ForwardAD1), .ForwardBD(ForwardBD1),
        .ForwardAE(ForwardAE1), .ForwardBE(ForwardBE1), .ForwardHIE(ForwardHIE1),
        .ForwardLOE(ForwardLOE1), .MdBusy(MdBusy1)
    );

    assign obs0 = {StallF0, StallD0, StallE0, FlushD0, FlushE0, FlushM0, ForwardAD0, ForwardBD0,
                   ForwardAE0, ForwardBE0, ForwardHIE0, ForwardLOE0, MdBusy0};
    assign obs1 = {StallF1, StallD1, StallE1, FlushD1, FlushE1, FlushM1, ForwardAD1, ForwardBD1,
                   ForwardAE1, ForwardBE1, ForwardHIE1, ForwardLOE1, MdBusy1};

    function automatic logic [16:0] mk(input logic sf, input logic sd, input logic se,
                                       input logic fd, input logic fe, input logic fm,
                                       input logic fad, input logic fbd,
                                       input logic [1:0] fae, input logic [1:0] fbe,
                                       input logic [1:0] fhi, input logic [1:0] flo,
                                       input logic busy);
        return {sf, sd, se, fd, fe, fm, fad, fbd, fae, fbe, fhi, flo, busy};
    endfunction

    task automatic push(input string t, input logic [16:0] e);
        exp_q.push_back(e);
        tag_q.push_back(t);
    endtask

    task automatic check(input logic [16:0] obs);
        logic [16:0] e;
        string       t;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $error("FAIL scoreboard_empty observed=%h expected=none", obs);
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            assert (obs === e) else begin
                bad++;
                $error("FAIL %s observed=%h expected=%h", t, obs, e);
            end
        end
    endtask

    task automatic check_cnt(input string t, input int obs, input int e);
        total++;
        assert (obs === e) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", t, obs, e);
        end
    endtask

    task automatic idle_in();
        RsD = 0; RtD = 0; RsE = 0; RtE = 0; WriteRegE = 0; WriteRegM = 0; WriteRegW = 0;
        BranchD = 0; RegWriteE = 0; MulStartE = 0; DivStartE = 0; RegWriteM = 0; RegWriteW = 0;
        MemtoRegE = 2'b00; MemtoRegM = 2'b00;
        HIWriteM = 0; LOWriteM = 0; HIWriteW = 0; LOWriteW = 0; ExceptM = 0;
    endtask

    task automatic step();
        @(negedge clk);
        idle_in();
    endtask

    localparam logic [16:0] ZERO = 17'h0;

    initial begin
        idle_in();
        #2;
        push("reset_u0", ZERO); check(obs0);
        push("reset_u1", ZERO); check(obs1);
        @(negedge clk);
        rst = 1'b1;

        // GPR forwarding into E
        step(); RsE = 3; RegWriteM = 1; WriteRegM = 3;
        push("fwd_ae_m", mk(0,0,0,0,0,0,0,0,2'b10,2'b00,2'b00,2'b00,0)); #2 check(obs0);
        step(); RsE = 3; RegWriteM = 1; WriteRegM = 3; RegWriteW = 1; WriteRegW = 3;
        push("fwd_ae_m_beats_w", mk(0,0,0,0,0,0,0,0,2'b10,2'b00,2'b00,2'b00,0)); #2 check(obs0);
        step(); RtE = 9; RegWriteW = 1; WriteRegW = 9;
        push("fwd_be_w", mk(0,0,0,0,0,0,0,0,2'b00,2'b01,2'b00,2'b00,0)); #2 check(obs0);
        step(); RsE = 0; RegWriteM = 1; WriteRegM = 0;
        push("fwd_r0_none", ZERO); #2 check(obs0);

        // load-use
        step(); MemtoRegE = 2'b11; RtE = 5; RsD = 5;
        push("lw_rs", mk(1,1,0,0,1,0,0,0,2'b00,2'b00,2'b00,2'b00,0)); #2 check(obs0);
        step(); MemtoRegE = 2'b11; RtE = 5; RtD = 5;
        push("lw_rt", mk(1,1,0,0,1,0,0,0,2'b00,2'b00,2'b00,2'b00,0)); #2 check(obs0);
        step(); MemtoRegE = 2'b11; RtE = 0; RsD = 0;
        push("lw_rt0", ZERO); #2 check(obs0);
        step(); MemtoRegE = 2'b11; RtE = 5; RsD = 6;
        push("lw_nomatch", ZERO); #2 check(obs0);

        // branch hazards
        step(); BranchD = 1; RegWriteE = 1; WriteRegE = 4; RsD = 4;
        push("br_e", mk(1,1,0,0,1,0,0,0,2'b00,2'b00,2'b00,2'b00,0)); #2 check(obs0);
        step(); BranchD = 0; RegWriteE = 1; WriteRegE = 4; RsD = 4;
        push("br_none", ZERO); #2 check(obs0);
        step(); BranchD = 1; MemtoRegM = 2'b11; WriteRegM = 7; RtD = 7;
        push("br_m_load", mk(1,1,0,0,1,0,0,0,2'b00,2'b00,2'b00,2'b00,0)); #2 check(obs0);
        step(); BranchD = 1; RegWriteE = 1; WriteRegE = 0;
        push("br_r0", ZERO); #2 check(obs0);

        // D-stage forwarding
        step(); RegWriteM = 1; WriteRegM = 6; RsD = 6; RtD = 6;
        push("fwd_d", mk(0,0,0,0,0,0,1,1,2'b00,2'b00,2'b00,2'b00,0)); #2 check(obs0);
        step(); RegWriteM = 1; MemtoRegM = 2'b01; WriteRegM = 6; RsD = 6;
        push("fwd_d_not_alu", ZERO); #2 check(obs0);

        // HI/LO forwarding
        step(); MemtoRegE = 2'b10; HIWriteM = 1; HIWriteW = 1;
        push("hi_m", mk(0,0,0,0,0,0,0,0,2'b00,2'b00,2'b01,2'b00,0)); #2 check(obs0);
        step(); MemtoRegE = 2'b10; HIWriteW = 1;
        push("hi_w", mk(0,0,0,0,0,0,0,0,2'b00,2'b00,2'b10,2'b00,0)); #2 check(obs0);
        step(); MemtoRegE = 2'b01; LOWriteW = 1;
        push("lo_w", mk(0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,2'b10,0)); #2 check(obs0);
        step(); MemtoRegE = 2'b10; LOWriteM = 1;
        push("lo_wrong_op", ZERO); #2 check(obs0);

        // MUL: two-cycle instance stalls once after the start cycle, single-cycle never
        step(); MulStartE = 1;
        push("mul_start_u0", mk(1,1,1,0,0,1,0,0,2'b00,2'b00,2'b00,2'b00,0));
        push("mul_start_u1", ZERO);
        #2 check(obs0); check(obs1);
        step();
        push("mul_busy_u0", mk(1,1,1,0,0,1,0,0,2'b00,2'b00,2'b00,2'b00,1));
        push("mul_busy_u1", ZERO);
        #2 check(obs0); check(obs1);
        step();
        push("mul_done_u0", mk(0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,1));
        push("mul_done_u1", ZERO);
        #2 check(obs0); check(obs1);
        step();
        push("mul_idle_u0", ZERO); #2 check(obs0);

        // DIV occupancy
        step(); DivStartE = 1;
        push("div_start", mk(1,1,1,0,0,1,0,0,2'b00,2'b00,2'b00,2'b00,0)); #2 check(obs0);
        n_all = 0; n_any = 0; n_busy = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            #2;
            if (StallF0 && StallD0 && StallE0 && FlushM0) n_all++;
            if (StallF0 || StallD0 || StallE0 || FlushM0 || FlushE0 || FlushD0) n_any++;
            if (MdBusy0) n_busy++;
        end
        check_cnt("div_stall_cycles", n_all, 31);
        check_cnt("div_any_ctrl_cycles", n_any, 31);
        check_cnt("div_busy_cycles", n_busy, 32);

        // exception while BUSY at cnt=10, also overriding a load-use hazard
        step(); DivStartE = 1;
        for (int i = 0; i < 21; i++) step();
        step(); ExceptM = 1; MemtoRegE = 2'b11; RtE = 5; RsD = 5;
        push("except_flush", mk(0,0,0,1,1,1,0,0,2'b00,2'b00,2'b00,2'b00,1)); #2 check(obs0);
        step();
        push("except_idle", ZERO); #2 check(obs0);

        // asynchronous reset mid-DIV
        step(); DivStartE = 1;
        for (int i = 0; i < 5; i++) step();
        #2;
        push("pre_reset_busy", mk(1,1,1,0,0,1,0,0,2'b00,2'b00,2'b00,2'b00,1)); check(obs0);
        rst = 1'b0;
        #1;
        push("async_reset", ZERO); check(obs0);
        MemtoRegE = 2'b10; HIWriteW = 1;
        #1;
        push("reset_hi_w", mk(0,0,0,0,0,0,0,0,2'b00,2'b00,2'b10,2'b00,0)); check(obs0);
        @(negedge clk);
        rst = 1'b1;
        step();
        push("post_reset_idle", ZERO); #2 check(obs0);

        check_cnt("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
